// File: rtl/tx_mac_pkg.sv
// Shared constants, FSM state type and byte-mask helper for the TX frame counter.
// Build option: TX_JUMBO_EN raises the legal frame_len ceiling from MAX_LEN to JUMBO_LEN.
package tx_mac_pkg;

  localparam int MIN_LEN   = 60;
  localparam int HDR_LEN   = 14;
  localparam int MAX_LEN   = 1518;
  localparam int JUMBO_LEN = 9018;

`ifdef TX_JUMBO_EN
  localparam int LEN_LIMIT = JUMBO_LEN;
`else
  localparam int LEN_LIMIT = MAX_LEN;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } tx_cnt_state_t;

  // A remainder of zero means the tail word is completely full.
  function automatic logic [7:0] tail_mask(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return 8'hFF;
    end
    return 8'hFF >> (4'd8 - {1'b0, rem});
  endfunction

endpackage

// File: rtl/tx_frame_counter_if.sv
// Client-side bundle of the TX frame counter: frame request, beat advance and per-beat status.
interface tx_frame_counter_if;

  logic        start;
  logic [13:0] frame_len;
  logic        advance;
  logic        busy;
  logic        data_phase;
  logic        pad_phase;
  logic        last_word;
  logic [10:0] word_cnt;
  logic [7:0]  data_mask;
  logic [7:0]  frame_mask;
  logic        done;
  logic        len_err;

  modport master (
    output start, frame_len, advance,
    input  busy, data_phase, pad_phase, last_word, word_cnt,
           data_mask, frame_mask, done, len_err
  );

  modport slave (
    input  start, frame_len, advance,
    output busy, data_phase, pad_phase, last_word, word_cnt,
           data_mask, frame_mask, done, len_err
  );

endinterface

// File: rtl/tx_len_calc.sv
// Combinational frame-length decode: word counts, tail remainders and legality.
// Build option: TX_JUMBO_EN (through tx_mac_pkg::LEN_LIMIT) widens the legal range.
module tx_len_calc
  import tx_mac_pkg::*;
(
  input  logic [13:0] i_frame_len,
  output logic [10:0] o_data_words,
  output logic [10:0] o_total_words,
  output logic [2:0]  o_d_rem,
  output logic [2:0]  o_f_rem,
  output logic        o_len_ok
);

  logic [13:0] w_eff_len;

  // Short frames are stretched to the minimum length; the stretch becomes pad.
  always_comb begin
    w_eff_len = (i_frame_len < 14'(MIN_LEN)) ? 14'(MIN_LEN) : i_frame_len;
  end

  // Ceiling divide by 8 as whole words plus one for any partial word.
  assign o_data_words  = i_frame_len[13:3] + {10'd0, |i_frame_len[2:0]};
  assign o_total_words = w_eff_len[13:3]   + {10'd0, |w_eff_len[2:0]};
  assign o_d_rem       = i_frame_len[2:0];
  assign o_f_rem       = w_eff_len[2:0];
  assign o_len_ok      = (i_frame_len >= 14'(HDR_LEN)) && (i_frame_len <= 14'(LEN_LIMIT));

endmodule

// File: rtl/tx_frame_counter.sv
// TX word sequencer: walks the 64-bit beats of a frame, flags data/pad/last and drives byte masks.
// Build option: TX_JUMBO_EN allows frame_len up to JUMBO_LEN (up to 1128 words).
//
// state | meaning
// IDLE  | no frame; outputs 0; start is sampled here (also in the done cycle)
// DATA  | current word carries client bytes
// PAD   | current word is all pad up to the minimum frame length
module tx_frame_counter
  import tx_mac_pkg::*;
(
  input logic              rxclk,
  input logic              reset,
  tx_frame_counter_if.slave bus
);

  tx_cnt_state_t r_state;
  tx_cnt_state_t w_state_nxt;
  logic [10:0]   r_word_cnt;
  logic [10:0]   w_cnt_nxt;
  logic [10:0]   r_data_words;
  logic [10:0]   r_total_words;
  logic [2:0]    r_d_rem;
  logic [2:0]    r_f_rem;
  logic          r_done;
  logic          r_len_err;
  logic          w_latch;
  logic          w_done_nxt;
  logic          w_len_err_nxt;

  logic [10:0]   w_data_words;
  logic [10:0]   w_total_words;
  logic [2:0]    w_d_rem;
  logic [2:0]    w_f_rem;
  logic          w_len_ok;
  logic          w_busy;
  logic          w_last_data;
  logic          w_last_frame;

  tx_len_calc u_len_calc (
    .i_frame_len   (bus.frame_len),
    .o_data_words  (w_data_words),
    .o_total_words (w_total_words),
    .o_d_rem       (w_d_rem),
    .o_f_rem       (w_f_rem),
    .o_len_ok      (w_len_ok)
  );

  assign w_last_data  = (r_word_cnt == r_data_words - 11'd1);
  assign w_last_frame = (r_word_cnt == r_total_words - 11'd1);

  // Next-state, word counter and pulse decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_word_cnt;
    w_latch       = 1'b0;
    w_done_nxt    = 1'b0;
    w_len_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_len_ok) begin
            w_latch     = 1'b1;
            w_cnt_nxt   = 11'd0;
            w_state_nxt = DATA;
          end else begin
            w_len_err_nxt = 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.advance) begin
          if (w_last_data) begin
            if (r_data_words < r_total_words) begin
              w_state_nxt = PAD;
              w_cnt_nxt   = r_word_cnt + 11'd1;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = 11'd0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_word_cnt + 11'd1;
          end
        end
      end
      PAD: begin
        if (bus.advance) begin
          if (w_last_frame) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 11'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_word_cnt + 11'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 11'd0;
      end
    endcase
  end

  // State and word counter registers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_word_cnt <= 11'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_cnt_nxt;
    end
  end

  // Length decode is captured at an accepted start and held for the whole frame.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_data_words  <= 11'd0;
      r_total_words <= 11'd0;
      r_d_rem       <= 3'd0;
      r_f_rem       <= 3'd0;
    end else if (w_latch) begin
      r_data_words  <= w_data_words;
      r_total_words <= w_total_words;
      r_d_rem       <= w_d_rem;
      r_f_rem       <= w_f_rem;
    end
  end

  // One-cycle done and len_err pulses.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_len_err <= w_len_err_nxt;
    end
  end

  assign w_busy         = (r_state != IDLE);
  assign bus.busy       = w_busy;
  assign bus.data_phase = (r_state == DATA);
  assign bus.pad_phase  = (r_state == PAD);
  assign bus.word_cnt   = w_busy ? r_word_cnt : 11'd0;
  assign bus.last_word  = w_busy && w_last_frame;
  assign bus.data_mask  = (r_state != DATA) ? 8'h00 :
                          (w_last_data ? tail_mask(r_d_rem) : 8'hFF);
  assign bus.frame_mask = !w_busy ? 8'h00 :
                          (w_last_frame ? tail_mask(r_f_rem) : 8'hFF);
  assign bus.done       = r_done;
  assign bus.len_err    = r_len_err;

endmodule

// File: tb/tb_tx_frame_counter.sv
// Self-checking bench for tx_frame_counter: table vectors, corner sequences and random frames.
module tb_tx_frame_counter;

`ifdef TX_JUMBO_EN
  localparam int LIMIT = 9018;
  localparam bit JUMBO = 1'b1;
`else
  localparam int LIMIT = 1518;
  localparam bit JUMBO = 1'b0;
`endif

  logic rxclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 rxclk = ~rxclk;

  tx_frame_counter_if bus ();

  tx_frame_counter dut (
    .rxclk (rxclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int len;
    int words;
    int ldm;
    int lfm;
    bit err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  // Low n byte lanes set, clamped to 0..8.
  function automatic int bmask(input int n);
    int m = 0;
    for (int b = 0; b < 8; b++) if (b < n) m |= (1 << b);
    return m;
  endfunction

  task automatic step();
    @(posedge rxclk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},       bus.busy,       0);
    chk({tag, ".data_phase"}, bus.data_phase, 0);
    chk({tag, ".pad_phase"},  bus.pad_phase,  0);
    chk({tag, ".last_word"},  bus.last_word,  0);
    chk({tag, ".word_cnt"},   bus.word_cnt,   0);
    chk({tag, ".data_mask"},  bus.data_mask,  0);
    chk({tag, ".frame_mask"}, bus.frame_mask, 0);
  endtask

  // Expected beat i of a frame from byte arithmetic: bytes left in each lane group.
  task automatic chk_word(input int len, input int i);
    int    eff = (len < 60) ? 60 : len;
    int    dw  = (len + 7) / 8;
    int    tw  = (eff + 7) / 8;
    string p   = $sformatf("len%0d.w%0d", len, i);
    chk({p, ".busy"},       bus.busy,       1);
    chk({p, ".word_cnt"},   bus.word_cnt,   i);
    chk({p, ".data_phase"}, bus.data_phase, int'(i < dw));
    chk({p, ".pad_phase"},  bus.pad_phase,  int'(i >= dw));
    chk({p, ".last_word"},  bus.last_word,  int'(i == tw - 1));
    chk({p, ".data_mask"},  bus.data_mask,  bmask(len - 8 * i));
    chk({p, ".frame_mask"}, bus.frame_mask, bmask(eff - 8 * i));
    chk({p, ".done"},       bus.done,       0);
    chk({p, ".len_err"},    bus.len_err,    0);
  endtask

  // Issues start in the current cycle and walks the frame; returns in the done cycle.
  task automatic run_frame(input int len, input int stall_at, input bit rnd_stall,
                           output int words, output int ldm, output int lfm, output bit err);
    int eff = (len < 60) ? 60 : len;
    int dw  = (len + 7) / 8;
    int tw  = (eff + 7) / 8;
    int n;
    words = 0;
    ldm   = 0;
    lfm   = 0;
    err   = 1'b0;
    bus.frame_len = 14'(len);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    if (!(len >= 14 && len <= LIMIT)) begin
      err = bus.len_err;
      chk($sformatf("len%0d.err_busy", len), bus.busy, 0);
      step();
      chk($sformatf("len%0d.err_pulse_end", len), bus.len_err, 0);
      chk($sformatf("len%0d.err_busy2", len), bus.busy, 0);
      return;
    end
    for (int i = 0; i < tw; i++) begin
      chk_word(len, i);
      if (bus.busy) words++;
      if (i == dw - 1) ldm = bus.data_mask;
      if (i == tw - 1) lfm = bus.frame_mask;
      if (i == stall_at) n = 5;
      else if (rnd_stall && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
      else n = 0;
      for (int s = 0; s < n; s++) begin
        bus.advance = 1'b0;
        if (i == stall_at && s == 2) begin
          bus.start     = 1'b1;
          bus.frame_len = 14'd10;
        end
        step();
        bus.start = 1'b0;
        chk_word(len, i);
      end
      bus.advance = 1'b1;
      step();
      bus.advance = 1'b0;
    end
    chk($sformatf("len%0d.done", len), bus.done, 1);
    chk($sformatf("len%0d.done_busy", len), bus.busy, 0);
  endtask

  initial begin
    int w, d, f;
    bit e;
    int len, r;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.advance   = 1'b0;
    bus.frame_len = 14'd0;
    #2;
    chk_idle("reset");
    chk("reset.done", bus.done, 0);
    chk("reset.len_err", bus.len_err, 0);
    repeat (3) @(posedge rxclk);
    #3;
    reset = 1'b0;
    step();
    chk_idle("post_reset");

    tbl.push_back('{100,  13,  'h0F, 'h0F, 1'b0});
    tbl.push_back('{40,   8,   'hFF, 'h0F, 1'b0});
    tbl.push_back('{57,   8,   'h01, 'h0F, 1'b0});
    tbl.push_back('{60,   8,   'h0F, 'h0F, 1'b0});
    tbl.push_back('{64,   8,   'hFF, 'hFF, 1'b0});
    tbl.push_back('{14,   8,   'h3F, 'h0F, 1'b0});
    tbl.push_back('{10,   0,   0,    0,    1'b1});
    tbl.push_back('{13,   0,   0,    0,    1'b1});
    tbl.push_back('{1518, 190, 'h3F, 'h3F, 1'b0});
    if (JUMBO) begin
      tbl.push_back('{2000, 250,  'hFF, 'hFF, 1'b0});
      tbl.push_back('{9018, 1128, 'h03, 'h03, 1'b0});
    end else begin
      tbl.push_back('{2000, 0, 0, 0, 1'b1});
      tbl.push_back('{1519, 0, 0, 0, 1'b1});
    end
    tbl.push_back('{9019,  0, 0, 0, 1'b1});
    tbl.push_back('{16383, 0, 0, 0, 1'b1});

    foreach (tbl[k]) begin
      run_frame(tbl[k].len, -1, 1'b0, w, d, f, e);
      chk($sformatf("tbl%0d.err", tbl[k].len), e, tbl[k].err);
      if (!tbl[k].err) begin
        chk($sformatf("tbl%0d.words", tbl[k].len), w, tbl[k].words);
        chk($sformatf("tbl%0d.last_dmask", tbl[k].len), d, tbl[k].ldm);
        chk($sformatf("tbl%0d.last_fmask", tbl[k].len), f, tbl[k].lfm);
      end
    end

    // Stall 5 cycles mid-frame with an ignored start in the middle of the stall.
    run_frame(100, 6, 1'b0, w, d, f, e);
    chk("stall.words", w, 13);

    // Reset at word 3 of a 64-byte frame, then a clean frame.
    step();
    bus.frame_len = 14'd64;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_word(64, i);
      bus.advance = 1'b1;
      step();
      bus.advance = 1'b0;
    end
    chk_word(64, 3);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid.done", bus.done, 0);
    step();
    chk_idle("rst_hold");
    chk("rst_hold.done", bus.done, 0);
    reset = 1'b0;
    step();
    chk_idle("rst_rel");
    chk("rst_rel.done", bus.done, 0);
    run_frame(64, -1, 1'b0, w, d, f, e);
    chk("rst_after.words", w, 8);
    chk("rst_after.last_fmask", f, 'hFF);

    // Random frames, back-to-back or with idle gaps, with random stalls.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(0, 13);
      else if (r == 1) len = $urandom_range(1519, 9100);
      else             len = $urandom_range(14, 1518);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk_idle("rnd_gap");
      end
      run_frame(len, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1, 1'b1, w, d, f, e);
      chk($sformatf("rnd%0d.err", len), e, int'(!(len >= 14 && len <= LIMIT)));
    end

    step();
    chk("final.done", bus.done, 0);
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
